// File: rtl/iobus_rect_fill_pkg.sv
// Shared OTTER IO constants, fill FSM state type and VGA pixel address helper.
// Also imported by the wrapper's MMIO decode so both sides agree on the VGA window.
package otter_io_pkg;

   localparam logic [31:0] VGA_RANGE_AD = 32'h2000_0000;
   localparam int          VGA_AD_BITS  = 13;
   localparam int          VGA_COLS     = 80;
   localparam int          VGA_ROWS     = 60;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_WRITE,
      S_FIN
   } fill_state_t;

   function automatic logic [31:0] vga_pix_ad(input logic [6:0] x, input logic [5:0] y);
      return VGA_RANGE_AD | {{(32-VGA_AD_BITS){1'b0}}, y, x};
   endfunction

endpackage

// File: rtl/iobus_rect_fill_if.sv
// Operand, IOBUS write and status bundle of the rectangle-fill engine.
// The master modport is the engine side; slave is the MCU/arbiter side.
interface iobus_rect_fill_if;
   logic        START;
   logic [6:0]  X0;
   logic [5:0]  Y0;
   logic [6:0]  W;
   logic [5:0]  H;
   logic [7:0]  COLOR;
   logic        GRANT;
   logic        IOBUS_WR;
   logic [31:0] IOBUS_ADDR;
   logic [31:0] IOBUS_OUT;
   logic        BUSY;
   logic        DONE;

   modport master (
      input  START, X0, Y0, W, H, COLOR, GRANT,
      output IOBUS_WR, IOBUS_ADDR, IOBUS_OUT, BUSY, DONE
   );

   modport slave (
      output START, X0, Y0, W, H, COLOR, GRANT,
      input  IOBUS_WR, IOBUS_ADDR, IOBUS_OUT, BUSY, DONE
   );
endinterface

// File: rtl/iobus_rect_fill_scan.sv
// rect_scan_ctr: raster x/y walker over [x0,xe) x [y0,ye), x fastest.
// Internal counters carry one extra bit so the end compare works past column 127 / row 63.
module rect_scan_ctr (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       adv,
   input  logic [6:0] x0,
   input  logic [5:0] y0,
   input  logic [7:0] xe,
   input  logic [6:0] ye,
   output logic [6:0] px,
   output logic [5:0] py,
   output logic       last
);
   logic [7:0] x;
   logic [6:0] y;
   logic [6:0] x0_q;
   logic [7:0] xe_q;
   logic [6:0] ye_q;
   logic       row_end;

   assign row_end = (x + 8'd1) == xe_q;
   assign last    = row_end && ((y + 7'd1) == ye_q);
   assign px      = x[6:0];
   assign py      = y[5:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         x    <= '0;
         y    <= '0;
         x0_q <= '0;
         xe_q <= '0;
         ye_q <= '0;
      end else if (load) begin
         x    <= {1'b0, x0};
         y    <= {1'b0, y0};
         x0_q <= x0;
         xe_q <= xe;
         ye_q <= ye;
      end else if (adv) begin
         if (row_end) begin
            x <= {1'b0, x0_q};
            y <= y + 7'd1;
         end else begin
            x <= x + 8'd1;
         end
      end
   end
endmodule

// File: rtl/iobus_rect_fill.sv
// Rectangle-fill IOBUS initiator: one write per pixel into the VGA framebuffer.
// Define RECT_FILL_CLIP_EN to clip the rectangle to the visible 80x60 area.
//
//   state   | meaning
//   S_IDLE  | waiting for START, operands latched on START
//   S_SETUP | end bounds computed, scan counter loaded, empty check
//   S_WRITE | IOBUS_WR high, pixel advances on GRANT
//   S_FIN   | DONE pulse
module iobus_rect_fill
   import otter_io_pkg::*;
(
   input logic               CLK,
   input logic               RESET,
   iobus_rect_fill_if.master bus
);
   fill_state_t state, state_nx;

   logic [6:0] x0_q, w_q;
   logic [5:0] y0_q, h_q;
   logic [7:0] color_q;
   logic [7:0] xe_sum, xe_c;
   logic [6:0] ye_sum, ye_c;
   logic       empty;
   logic [6:0] px;
   logic [5:0] py;
   logic       last, scan_ld, scan_adv;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= S_IDLE;
         x0_q    <= '0;
         y0_q    <= '0;
         w_q     <= '0;
         h_q     <= '0;
         color_q <= '0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && bus.START) begin
            x0_q    <= bus.X0;
            y0_q    <= bus.Y0;
            w_q     <= bus.W;
            h_q     <= bus.H;
            color_q <= bus.COLOR;
         end
      end
   end

   assign xe_sum = {1'b0, x0_q} + {1'b0, w_q};
   assign ye_sum = {1'b0, y0_q} + {1'b0, h_q};

`ifdef RECT_FILL_CLIP_EN
   assign xe_c = (xe_sum > 8'(VGA_COLS)) ? 8'(VGA_COLS) : xe_sum;
   assign ye_c = (ye_sum > 7'(VGA_ROWS)) ? 7'(VGA_ROWS) : ye_sum;
`else
   assign xe_c = xe_sum;
   assign ye_c = ye_sum;
`endif

   // Also covers an origin beyond the clipped edge, where the bound collapses below X0/Y0.
   assign empty = (xe_c <= {1'b0, x0_q}) || (ye_c <= {1'b0, y0_q});

   rect_scan_ctr u_scan (
      .clk  (CLK),
      .rst  (RESET),
      .load (scan_ld),
      .adv  (scan_adv),
      .x0   (x0_q),
      .y0   (y0_q),
      .xe   (xe_c),
      .ye   (ye_c),
      .px   (px),
      .py   (py),
      .last (last)
   );

   always_comb begin
      state_nx = state;
      scan_ld  = 1'b0;
      scan_adv = 1'b0;
      case (state)
         S_IDLE:  if (bus.START) state_nx = S_SETUP;
         S_SETUP: begin
            scan_ld  = 1'b1;
            state_nx = empty ? S_FIN : S_WRITE;
         end
         S_WRITE: begin
            scan_adv = bus.GRANT;
            if (bus.GRANT && last) state_nx = S_FIN;
         end
         S_FIN:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign bus.IOBUS_WR   = (state == S_WRITE);
   assign bus.IOBUS_ADDR = bus.IOBUS_WR ? vga_pix_ad(px, py) : 32'h0;
   assign bus.IOBUS_OUT  = bus.IOBUS_WR ? {24'h0, color_q} : 32'h0;
   assign bus.BUSY       = (state != S_IDLE);
   assign bus.DONE       = (state == S_FIN);
endmodule

// File: tb/tb_iobus_rect_fill.sv
// Self-checking bench for iobus_rect_fill: scoreboard of expected pixel writes.
// Build with or without RECT_FILL_CLIP_EN; the reference model follows the same macro.
module tb_iobus_rect_fill;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   iobus_rect_fill_if bus();

   iobus_rect_fill dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus.master)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [7:0]  exp_col;

   task automatic push_model(input int x0, input int y0, input int w, input int h);
      int xe = x0 + w;
      int ye = y0 + h;
`ifdef RECT_FILL_CLIP_EN
      if (xe > 80) xe = 80;
      if (ye > 60) ye = 60;
`endif
      for (int yy = y0; yy < ye; yy++)
         for (int xx = x0; xx < xe; xx++)
            exp_q.push_back(32'h2000_0000 | 32'(((yy % 64) << 7) | (xx % 128)));
   endtask

   task automatic start_rect(input int x0, input int y0, input int w, input int h,
                             input logic [7:0] col);
      @(negedge clk);
      bus.START = 1'b1;
      bus.X0    = 7'(x0);
      bus.Y0    = 6'(y0);
      bus.W     = 7'(w);
      bus.H     = 6'(h);
      bus.COLOR = col;
      exp_col   = col;
      push_model(x0, y0, w, h);
   endtask

   // mode 0: GRANT always high; mode 1: GRANT 1,0,0 repeating over write cycles.
   // exp_done < 0 means N+2 (2 when empty), N taken from the scoreboard.
   task automatic run_op(input string name, input int mode, input int exp_done);
      int          k = 0;
      int          wcnt = 0;
      int          want_done;
      bit          done = 0;
      bit          hold = 0;
      bit          g;
      logic [31:0] held, e;
      want_done = (exp_done >= 0) ? exp_done :
                  (exp_q.size() == 0) ? 2 : exp_q.size() + 2;
      while (!done && k < 300) begin
         @(negedge clk);
         k++;
         if (k == 1) bus.START = 1'b0;
         if (hold) begin
            n_checks++;
            if (bus.IOBUS_WR !== 1'b1 || bus.IOBUS_ADDR !== held ||
                bus.IOBUS_OUT !== {24'h0, exp_col}) begin
               n_fail++;
               $display("FAIL %s hold: wr=%b addr=%h data=%h, required wr=1 addr=%h data=%h",
                        name, bus.IOBUS_WR, bus.IOBUS_ADDR, bus.IOBUS_OUT, held, {24'h0, exp_col});
            end
            hold = 0;
         end
         if (bus.IOBUS_WR === 1'b1) begin
            g = (mode == 0) ? 1'b1 : (wcnt % 3 == 0);
            wcnt++;
            bus.GRANT = g;
            if (g) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL %s unexpected write: addr=%h, required no write", name, bus.IOBUS_ADDR);
               end else begin
                  e = exp_q.pop_front();
                  if (bus.IOBUS_ADDR !== e || bus.IOBUS_OUT !== {24'h0, exp_col}) begin
                     n_fail++;
                     $display("FAIL %s write: addr=%h data=%h, required addr=%h data=%h",
                              name, bus.IOBUS_ADDR, bus.IOBUS_OUT, e, {24'h0, exp_col});
                  end
               end
            end else begin
               held = bus.IOBUS_ADDR;
               hold = 1;
            end
         end else begin
            bus.GRANT = (mode == 0);
         end
         if (bus.DONE === 1'b1) begin
            done = 1;
            n_checks++;
            if (k != want_done || bus.BUSY !== 1'b1) begin
               n_fail++;
               $display("FAIL %s done: cycle=%0d busy=%b, required cycle=%0d busy=1",
                        name, k, bus.BUSY, want_done);
            end
            n_checks++;
            if (exp_q.size() != 0) begin
               n_fail++;
               $display("FAIL %s missing writes: remaining=%0d, required 0", name, exp_q.size());
            end
         end
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s timeout: no DONE after %0d cycles, required cycle %0d", name, k, want_done);
      end
      exp_q.delete();
   endtask

   task automatic check_idle(input string name);
      @(negedge clk);
      n_checks++;
      if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.IOBUS_WR !== 1'b0) begin
         n_fail++;
         $display("FAIL %s idle: busy=%b done=%b wr=%b, required 0 0 0",
                  name, bus.BUSY, bus.DONE, bus.IOBUS_WR);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.START = 1'b0; bus.X0 = '0; bus.Y0 = '0; bus.W = '0; bus.H = '0;
      bus.COLOR = '0;   bus.GRANT = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.IOBUS_WR !== 1'b0 || bus.IOBUS_ADDR !== 32'h0 || bus.IOBUS_OUT !== 32'h0 ||
          bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: wr=%b addr=%h out=%h busy=%b done=%b, required all 0",
                  bus.IOBUS_WR, bus.IOBUS_ADDR, bus.IOBUS_OUT, bus.BUSY, bus.DONE);
      end
      rst = 1'b0;
   endtask

   task automatic test_nominal();
      start_rect(2, 3, 3, 2, 8'hE0);
      run_op("nominal", 0, 8);
      check_idle("nominal");
   endtask

   task automatic test_backpressure();
      start_rect(2, 3, 3, 2, 8'h5A);
      run_op("backpressure", 1, 18);
      bus.GRANT = 1'b1;
   endtask

   task automatic test_empty();
      start_rect(5, 5, 0, 4, 8'hFF);
      run_op("empty_w", 0, 2);
      start_rect(5, 5, 4, 0, 8'hFF);
      run_op("empty_h", 0, 2);
   endtask

   task automatic test_clip();
      start_rect(78, 59, 5, 3, 8'h3C);
`ifdef RECT_FILL_CLIP_EN
      run_op("clip", 0, 4);
`else
      run_op("clip", 0, 17);
`endif
      start_rect(126, 10, 4, 1, 8'h81);
      run_op("xwrap", 0, -1);
   endtask

   task automatic test_back_to_back();
      start_rect(0, 0, 2, 1, 8'h11);
      run_op("b2b_a", 0, 4);
      start_rect(10, 20, 1, 2, 8'h22);
      run_op("b2b_b", 0, 4);
   endtask

   task automatic test_busy_reset();
      int          k = 0;
      bit          bad = 0;
      logic [31:0] e;
      start_rect(2, 3, 3, 2, 8'h1C);
      bus.GRANT = 1'b1;
      repeat (2) begin
         @(negedge clk);
         k++;
         bus.START = 1'b0;
      end
      // cycle 2: first write, and a START that must be ignored
      e = exp_q.pop_front();
      n_checks++;
      if (bus.IOBUS_WR !== 1'b1 || bus.IOBUS_ADDR !== e) begin
         n_fail++;
         $display("FAIL busy_first: wr=%b addr=%h, required wr=1 addr=%h", bus.IOBUS_WR, bus.IOBUS_ADDR, e);
      end
      bus.START = 1'b1; bus.X0 = 7'd40; bus.Y0 = 6'd40; bus.W = 7'd5; bus.H = 6'd5;
      @(negedge clk);
      bus.START = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (bus.IOBUS_WR !== 1'b1 || bus.IOBUS_ADDR !== e) begin
         n_fail++;
         $display("FAIL busy_second: wr=%b addr=%h, required wr=1 addr=%h", bus.IOBUS_WR, bus.IOBUS_ADDR, e);
      end
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.IOBUS_WR !== 1'b0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: wr=%b busy=%b done=%b, required 0 0 0",
                  bus.IOBUS_WR, bus.BUSY, bus.DONE);
      end
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.DONE !== 1'b0 || bus.IOBUS_WR !== 1'b0 || bus.BUSY !== 1'b0) bad = 1;
      end
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL post_reset: activity after reset, required idle with no DONE");
      end
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_backpressure();
      test_empty();
      test_clip();
      test_back_to_back();
      test_busy_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
